arb_seq_scheduler: RTL and testbench
====================================

// Module: arb_seq_scheduler
// PURPOSE
//  Programmable sequence scheduler that drives arbitrary-order count sequences, e.g. 0,1,2,3,6,5,7.
//  Holds a writable sequence table and runs it for N passes, or forever.
//  Presents each element to a downstream consumer over a valid/ready handshake.
//  Replaces hard-coded case-table counters: software loads the order, then issues start/stop.
// PARAMETERS
//  WIDTH  3  width of each sequence value
//  DEPTH  8  number of table entries (power of 2); AW = $clog2(DEPTH)
//  REP_W  8  width of the pass-count register
// PORTS
//  clock      in   1      single clock; all state updates on posedge
//  reset      in   1      synchronous, active-low reset
//  cfg_we     in   1      table write strobe
//  cfg_addr   in   AW     table write index
//  cfg_data   in   WIDTH  table write data
//  cfg_len    in   AW     index of last element (sequence length - 1); sampled at start
//  cfg_reps   in   REP_W  number of passes; 0 = run until stop; sampled at start
//  start      in   1      begin a run (honoured only in IDLE)
//  stop       in   1      abort a run (honoured only in RUN)
//  out_valid  out  1      out_value is offered
//  out_ready  in   1      consumer accepts out_value
//  out_value  out  WIDTH  current sequence element
//  out_index  out  AW     table index of out_value
//  wrap       out  1      out_valid && out_index == len_q (last element of a pass)
//  busy       out  1      state == RUN
//  done       out  1      one-cycle pulse on natural completion
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; idx=0; pass=0; len_q=DEPTH-1; reps_q=0.
//   - table[i] = i[WIDTH-1:0].
//   - All outputs 0; out_value=table[0]=0.
//   - Reset mid-run aborts immediately; no done pulse.
//  Transfer: out_valid && out_ready at a posedge.
//  States:
//   IDLE
//    - cfg_we writes table[cfg_addr]=cfg_data, visible the next cycle.
//    - start=1: latch len_q=cfg_len, reps_q=cfg_reps; set idx=0, pass=0; go to RUN.
//    - If cfg_we and start are both high, the write lands first, so the run sees the new entry.
//   RUN
//    - out_valid=1; out_value=table[idx]; out_index=idx.
//    - Latency: start at edge N gives out_valid=1 in the cycle after N.
//    - No transfer: idx, out_value and out_index are held stable.
//    - Transfer with idx<len_q: idx+1, so back-to-back output at 1 element per cycle.
//    - Transfer with idx==len_q (end of pass):
//        - reps_q!=0 && pass+1==reps_q: go to DONE.
//        - otherwise: idx=0, pass=pass+1.
//        - pass saturates at all-ones when reps_q==0.
//    - stop=1: go to IDLE next cycle with idx=0.
//        - A transfer in the same cycle still counts as consumed.
//        - stop has priority over any end-of-pass transition; no done pulse.
//    - start and cfg_we are ignored in RUN.
//   DONE
//    - Lasts one cycle: done=1, out_valid=0, busy=0, then IDLE.
//    - start is ignored in DONE.
//    - cfg_we is honoured in DONE.
//  Width rules:
//   - pass compares at REP_W bits, so reps_q up to 2^REP_W-1 is legal.
//   - len_q=0 gives single-element passes; wrap is asserted on every element.
//  out_value is registered table data, with no combinational path from out_ready.
//  After DONE or stop, the table keeps its contents until rewritten or reset.
// TESTING
//  1. Load 0,1,2,3,6,5,7; len=6, reps=2, ready=1, start.
//     -> 14 back-to-back outputs 0,1,2,3,6,5,7,0,1,2,3,6,5,7.
//     -> wrap on the 7th and 14th outputs; done pulses in the cycle after the last transfer.
//  2. Same table, len=6, reps=1, ready toggling 1,0,0,1,...
//     -> out_value stable while ready=0; no skipped or duplicated elements; 7 outputs total.
//  3. reps=0, ready=1; run 20 cycles, then assert stop.
//     -> sequence repeats 0,1,2,3,6,5,7; next cycle state IDLE, out_valid=0, done never pulses.
//  4. cfg_we to addr 0 with data 5 during RUN
//     -> ignored; outputs unchanged.
//     The same write in DONE -> next run starts with 5.
//  5. reset=0 mid-run (idx=3).
//     -> next cycle out_valid=0, busy=0, table back to identity; a new start gives 0,1,2,...
//  6. len=0, reps=3, table[0]=6, ready=1.
//     -> exactly three outputs of 6, each with wrap=1, then a done pulse.

Source files
------------

// File: rtl/arb_seq_scheduler.sv
// arb_seq_scheduler
//   Programmable sequence scheduler. Software loads an arbitrary-order table
//   of values, then issues start. The block walks table[0..len] for a set
//   number of passes, or until stop when the pass count is 0. Each element is
//   offered to a consumer over a valid/ready handshake.
//
// Ports
//   clock     : single clock, all state updates on posedge
//   reset     : synchronous, active-low
//   cfg_we    : table write strobe (honoured in IDLE and DONE)
//   cfg_addr  : table write index
//   cfg_data  : table write data
//   cfg_len   : index of last element of a pass, sampled at start
//   cfg_reps  : number of passes (0 = run until stop), sampled at start
//   start     : begin a run (IDLE only)
//   stop      : abort a run (RUN only)
//   out_valid : out_value is offered
//   out_ready : consumer accepts out_value
//   out_value : current sequence element
//   out_index : table index of out_value
//   wrap      : current element is the last of a pass
//   busy      : run in progress
//   done      : one-cycle pulse on natural completion
module arb_seq_scheduler #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int REP_W = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [AW-1:0]    cfg_len,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [AW-1:0]    out_index,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [AW-1:0]    len_q, len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic             tbl_we;
  logic             xfer;
  logic [REP_W-1:0] pass_inc;

  // Pass counter increments but sticks at all-ones; only reachable in
  // run-forever mode, since a finite run finishes before pass hits reps_q.
  function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign xfer     = out_valid && out_ready;
  assign pass_inc = pass_q + 1'b1;

  // Outputs are decoded from registered state and table contents only,
  // so nothing here depends combinationally on out_ready.
  assign out_value = tbl[idx_q];
  assign out_index = idx_q;
  assign wrap      = out_valid && (idx_q == len_q);

  // ---- state register ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      len_q   <= AW'(DEPTH - 1);
      reps_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
    end
  end

  // ---- sequence table ----
  // Written on the same edge that a start is taken, so a simultaneous
  // write is visible to the very first element of the run.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= WIDTH'(i);
      end
    end else if (tbl_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // ---- next-state and outputs ----
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    len_d     = len_q;
    reps_d    = reps_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    tbl_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tbl_we = cfg_we;
        if (start) begin
          len_d   = cfg_len;
          reps_d  = cfg_reps;
          idx_d   = '0;
          pass_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // stop wins over an end-of-pass completion; a same-cycle transfer
        // is simply consumed and the run ends without a done pulse.
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          if (idx_q != len_q) begin
            idx_d = idx_q + AW'(1);
          end else if ((reps_q != '0) && (pass_inc == reps_q)) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d  = '0;
            pass_d = sat_inc(pass_q);
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        tbl_we  = cfg_we;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_arb_seq_scheduler.sv
module tb_arb_seq_scheduler;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int REP_W = 8;
  localparam int AW    = 3;

  logic             clock;
  logic             reset;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [AW-1:0]    cfg_len;
  logic [REP_W-1:0] cfg_reps;
  logic             start;
  logic             stop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [AW-1:0]    out_index;
  logic             wrap;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;
  int expv_q[$];
  int seq7[7] = '{0, 1, 2, 3, 6, 5, 7};

  arb_seq_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_len  (cfg_len),
    .cfg_reps (cfg_reps),
    .start    (start),
    .stop     (stop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_index(out_index),
    .wrap     (wrap),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = WIDTH'(data);
    @(negedge clock);
    cfg_we   = 1'b0;
  endtask

  task automatic go(input int len, input int reps);
    cfg_len  = AW'(len);
    cfg_reps = REP_W'(reps);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    chk("latency_valid", out_valid, 1);
    chk("latency_busy", busy, 1);
  endtask

  // Walks the run from the current negedge. rmode 0: ready always high;
  // rmode 1: ready high one cycle in three. Every offered element is checked
  // against the expected queue whether or not it is taken, which also proves
  // it is held stable while ready is low. Returns on done or after max_cyc.
  task automatic consume(input string tag, input int len, input int max_cyc,
                         input int rmode, output int got, output int done_cyc);
    got      = 0;
    done_cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      out_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (out_valid) begin
        if (got < expv_q.size()) chk({tag, "_val"}, out_value, expv_q[got]);
        else                     chk({tag, "_extra"}, got, expv_q.size());
        chk({tag, "_idx"}, out_index, got % (len + 1));
        chk({tag, "_wrap"}, wrap, (got % (len + 1)) == len);
        if (out_ready) got++;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int got, dcyc;
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_len = '0; cfg_reps = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_value", out_value, 0);
    chk("rst_index", out_index, 0);
    reset = 1'b1;
    @(negedge clock);

    // 1: two passes, back-to-back
    for (int i = 0; i < 7; i++) cfg_write(i, seq7[i]);
    expv_q.delete();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 7; i++) expv_q.push_back(seq7[i]);
    out_ready = 1'b1;
    go(6, 2);
    consume("t1", 6, 40, 0, got, dcyc);
    chk("t1_count", got, 14);
    chk("t1_done_cyc", dcyc, 14);
    chk("t1_done_valid", out_valid, 0);
    chk("t1_done_busy", busy, 0);
    @(negedge clock);
    chk("t1_after_done", done, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: one pass, ready 1,0,0,...
    expv_q.delete();
    for (int i = 0; i < 7; i++) expv_q.push_back(seq7[i]);
    go(6, 1);
    consume("t2", 6, 60, 1, got, dcyc);
    chk("t2_count", got, 7);
    chk("t2_done_cyc", dcyc, 19);
    @(negedge clock);

    // 3: run forever, then stop
    out_ready = 1'b1;
    expv_q.delete();
    for (int p = 0; p < 3; p++) for (int i = 0; i < 7; i++) expv_q.push_back(seq7[i]);
    go(6, 0);
    consume("t3", 6, 20, 0, got, dcyc);
    chk("t3_count", got, 20);
    chk("t3_no_done", dcyc, -1);
    chk("t3_pre_stop_val", out_value, 7);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    chk("t3_stop_valid", out_valid, 0);
    chk("t3_stop_busy", busy, 0);
    chk("t3_stop_done", done, 0);
    chk("t3_stop_index", out_index, 0);
    @(negedge clock);
    chk("t3_still_idle", busy, 0);
    chk("t3_no_done_late", done, 0);

    // 4: write in RUN ignored, write in DONE honoured
    out_ready = 1'b0;
    go(6, 1);
    cfg_write(0, 5);
    chk("t4_run_we_val", out_value, 0);
    chk("t4_run_we_idx", out_index, 0);
    expv_q.delete();
    for (int i = 0; i < 7; i++) expv_q.push_back(seq7[i]);
    consume("t4a", 6, 40, 0, got, dcyc);
    chk("t4a_count", got, 7);
    chk("t4a_done", done, 1);
    cfg_write(0, 5);
    chk("t4_idle_after", busy, 0);
    expv_q.delete();
    expv_q.push_back(5);
    for (int i = 1; i < 7; i++) expv_q.push_back(seq7[i]);
    go(6, 1);
    consume("t4b", 6, 40, 0, got, dcyc);
    chk("t4b_count", got, 7);
    @(negedge clock);

    // 5: reset mid-run restores the identity table
    out_ready = 1'b1;
    go(6, 0);
    for (int c = 0; c < 10; c++) begin
      if (out_index == 3) break;
      @(negedge clock);
    end
    chk("t5_at_idx3", out_index, 3);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_value", out_value, 0);
    expv_q.delete();
    for (int i = 0; i < 8; i++) expv_q.push_back(i);
    go(7, 1);
    consume("t5", 7, 40, 0, got, dcyc);
    chk("t5_count", got, 8);
    @(negedge clock);

    // 6: single-element passes, start in DONE ignored
    cfg_write(0, 6);
    expv_q.delete();
    for (int i = 0; i < 3; i++) expv_q.push_back(6);
    go(0, 3);
    consume("t6", 0, 20, 0, got, dcyc);
    chk("t6_count", got, 3);
    chk("t6_done_cyc", dcyc, 3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t6_start_in_done", busy, 0);
    @(negedge clock);
    chk("t6_stays_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
